// File: rtl/pc_unit.sv
// Program-counter unit: holds the architectural PC, picks the next PC each cycle,
// sequences BOOT/RUN/HALT, traps misaligned redirects and counts retired instructions.
module pc_unit #(
  parameter int              XLEN         = 32,
  parameter int              INC          = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter int              CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [XLEN-1:0]  branch_target,
  input  logic             jump,
  input  logic [XLEN-1:0]  jump_target,
  input  logic             trap,
  input  logic             halt_req,
  input  logic             resume,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  pc_plus_inc,
  output logic             pc_valid,
  output logic             misaligned,
  output logic [XLEN-1:0]  bad_addr,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] INC_V = XLEN'(INC);

  state_t            r_state;
  logic [XLEN-1:0]   r_pc;
  logic              r_misaligned;
  logic [XLEN-1:0]   r_bad_addr;
  logic [CNT_W-1:0]  r_retired;

  state_t            w_next_state;
  logic [XLEN-1:0]   w_next_pc;
  logic              w_next_mis;
  logic [XLEN-1:0]   w_next_bad;
  logic              w_retire;
  logic              w_redirect;
  logic [XLEN-1:0]   w_redir_tgt;
  logic              w_tgt_mis;
  logic [XLEN-1:0]   w_pc_plus_inc;

  assign w_pc_plus_inc = r_pc + INC_V;
  assign w_redirect    = jump | branch_taken;
  assign w_redir_tgt   = jump ? jump_target : branch_target;
  assign w_tgt_mis     = (w_redir_tgt[1:0] != 2'b00);

  // Next-state / next-PC selection; halt_req only loses to trap.
  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_next_mis   = 1'b0;
    w_next_bad   = r_bad_addr;
    w_retire     = 1'b0;
    case (r_state)
      ST_BOOT: begin
        w_next_state = ST_RUN;
      end
      ST_RUN: begin
        if (trap) begin
          w_next_pc = TRAP_VECTOR;
          w_retire  = 1'b1;
        end else if (halt_req) begin
          w_next_state = ST_HALT;
        end else if (w_redirect) begin
          w_retire = 1'b1;
          if (w_tgt_mis) begin
            w_next_pc  = TRAP_VECTOR;
            w_next_mis = 1'b1;
            w_next_bad = w_redir_tgt;
          end else begin
            w_next_pc = w_redir_tgt;
          end
        end else if (stall) begin
          w_next_pc = r_pc;
        end else begin
          w_next_pc = w_pc_plus_inc;
          w_retire  = 1'b1;
        end
      end
      ST_HALT: begin
        if (trap) begin
          w_next_state = ST_RUN;
          w_next_pc    = TRAP_VECTOR;
        end else if (resume) begin
          w_next_state = ST_RUN;
        end else begin
          w_next_state = ST_HALT;
        end
      end
      default: begin
        w_next_state = ST_BOOT;
        w_next_pc    = RESET_VECTOR;
      end
    endcase
  end

  // Architectural state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_BOOT;
      r_pc         <= RESET_VECTOR;
      r_misaligned <= 1'b0;
      r_bad_addr   <= {XLEN{1'b0}};
      r_retired    <= {CNT_W{1'b0}};
    end else begin
      r_state      <= w_next_state;
      r_pc         <= w_next_pc;
      r_misaligned <= w_next_mis;
      r_bad_addr   <= w_next_bad;
      if (w_retire) begin
        r_retired <= r_retired + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        r_retired <= r_retired;
      end
    end
  end

  assign pc          = r_pc;
  assign pc_plus_inc = w_pc_plus_inc;
  assign pc_valid    = (r_state == ST_RUN);
  assign misaligned  = r_misaligned;
  assign bad_addr    = r_bad_addr;
  assign retired     = r_retired;

endmodule
